// File: rtl/osc_meas_sequencer.sv
// Ring-oscillator measurement sequencer: walks the enabled mask, clears/settles/counts/holds each oscillator, writes {sel, count} to SRAM.
// Latency per oscillator: 1 + max(S,1) + max(C,1) + 2 + 1 + 1 cycles when wr_ack_i arrives on the first request cycle.
// Backpressure: WRITE holds wr_req_o/addr/data stable until wr_ack_i; a stop seen during WRITE waits for the ack before idling.
module osc_meas_sequencer #(
  parameter int NUM_OSC = 10,
  parameter int SEL_W   = 5,
  parameter int CNT_W   = 16,
  parameter int TIMER_W = 24,
  parameter int ADDR_W  = 10
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   cont_mode_i,
  input  logic [NUM_OSC-1:0]     osc_mask_i,
  input  logic [TIMER_W-1:0]     settle_cycles_i,
  input  logic [TIMER_W-1:0]     count_cycles_i,
  input  logic [CNT_W-1:0]       osc_count_i,
  output logic [NUM_OSC-1:0]     osc_en_o,
  output logic [SEL_W-1:0]       osc_sel_o,
  output logic                   cnt_rstn_o,
  output logic                   cnt_en_o,
  output logic                   wr_req_o,
  input  logic                   wr_ack_i,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic [SEL_W+CNT_W-1:0] wr_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [15:0]            round_cnt_o
);

  typedef enum logic [2:0] {IDLE, CLR, SETTLE, COUNT, HOLD, WRITE, NEXT} state_t;

  state_t               state_q, state_d;
  logic [NUM_OSC-1:0]   mask_q, mask_d;
  logic [TIMER_W-1:0]   settle_q, settle_d;
  logic [TIMER_W-1:0]   count_q, count_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 stop_pend_q, stop_pend_d;

  logic [SEL_W-1:0]       sel_d;
  logic [ADDR_W-1:0]      addr_d;
  logic [SEL_W+CNT_W-1:0] data_d;
  logic [15:0]            round_d;
  logic                   done_d;

  logic [NUM_OSC-1:0]   osc_en_d;
  logic                 cnt_rstn_d;
  logic                 cnt_en_d;
  logic                 wr_req_d;
  logic                 busy_d;

  logic                 has_higher;
  logic [SEL_W-1:0]     higher_sel;

  // Index of the lowest set bit of a mask (0 when the mask is empty).
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_OSC-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_OSC - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // Timer reload value: a zero-length window still lasts one cycle.
  function automatic logic [TIMER_W-1:0] win_load(input logic [TIMER_W-1:0] w);
    return (w == '0) ? '0 : (w - TIMER_W'(1));
  endfunction

  // Search the latched mask for the nearest set bit above the current oscillator.
  always_comb begin
    has_higher = 1'b0;
    higher_sel = '0;
    for (int i = NUM_OSC - 1; i >= 0; i--) begin
      if (mask_q[i] && (SEL_W'(i) > osc_sel_o)) begin
        has_higher = 1'b1;
        higher_sel = SEL_W'(i);
      end
    end
  end

  // Next-state and datapath update logic for the measurement sequence.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    settle_d    = settle_q;
    count_d     = count_q;
    timer_d     = timer_q;
    stop_pend_d = stop_pend_q;
    sel_d       = osc_sel_o;
    addr_d      = wr_addr_o;
    data_d      = wr_data_o;
    round_d     = round_cnt_o;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start_i && !stop_i && (osc_mask_i != '0)) begin
          mask_d   = osc_mask_i;
          settle_d = settle_cycles_i;
          count_d  = count_cycles_i;
          addr_d   = '0;
          round_d  = '0;
          sel_d    = lowest_set(osc_mask_i);
          state_d  = CLR;
        end
      end
      CLR: begin
        if (stop_i) begin
          state_d = IDLE;
        end else begin
          timer_d = win_load(settle_q);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          timer_d = win_load(count_q);
          state_d = COUNT;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      COUNT: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          // Two idle cycles let the oscillator counter settle before sampling.
          timer_d = TIMER_W'(1);
          state_d = HOLD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      HOLD: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          data_d  = {osc_sel_o, osc_count_i};
          state_d = WRITE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      WRITE: begin
        // The request is never withdrawn; a stop is remembered until the ack.
        if (stop_i) stop_pend_d = 1'b1;
        if (wr_ack_i) begin
          addr_d  = wr_addr_o + ADDR_W'(1);
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (!has_higher) round_d = round_cnt_o + 16'd1;
        if (stop_i || stop_pend_q) begin
          state_d = IDLE;
        end else if (has_higher) begin
          sel_d   = higher_sel;
          state_d = CLR;
        end else if (cont_mode_i && (osc_mask_i != '0)) begin
          mask_d   = osc_mask_i;
          settle_d = settle_cycles_i;
          count_d  = count_cycles_i;
          sel_d    = lowest_set(osc_mask_i);
          state_d  = CLR;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (state_d == IDLE)) done_d = 1'b1;
  end

  // Decode the control outputs from the upcoming state so they register in step with it.
  always_comb begin
    osc_en_d   = '0;
    cnt_rstn_d = (state_d != IDLE) && (state_d != CLR);
    cnt_en_d   = (state_d == COUNT);
    wr_req_d   = (state_d == WRITE);
    busy_d     = (state_d != IDLE);
    if ((state_d == SETTLE) || (state_d == COUNT)) begin
      for (int i = 0; i < NUM_OSC; i++) begin
        osc_en_d[i] = (sel_d == SEL_W'(i));
      end
    end
  end

  // Sequencer state and latched round configuration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      settle_q    <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      settle_q    <= settle_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      osc_en_o    <= '0;
      osc_sel_o   <= '0;
      cnt_rstn_o  <= 1'b0;
      cnt_en_o    <= 1'b0;
      wr_req_o    <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      round_cnt_o <= '0;
    end else begin
      osc_en_o    <= osc_en_d;
      osc_sel_o   <= sel_d;
      cnt_rstn_o  <= cnt_rstn_d;
      cnt_en_o    <= cnt_en_d;
      wr_req_o    <= wr_req_d;
      wr_addr_o   <= addr_d;
      wr_data_o   <= data_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      round_cnt_o <= round_d;
    end
  end

endmodule

// File: tb/tb_osc_meas_sequencer.sv
// Scoreboard bench for osc_meas_sequencer: expected SRAM writes are queued by the stimulus, a monitor checks every request cycle.
// Latency: checks sample at the falling edge, away from the active rising edge.
// Backpressure: a bench ack driver either ties wr_ack_i high or delays it a programmable number of request cycles.
module tb_osc_meas_sequencer;

  localparam int NUM_OSC = 10;
  localparam int SEL_W   = 5;
  localparam int CNT_W   = 16;
  localparam int TIMER_W = 24;
  localparam int ADDR_W  = 10;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [SEL_W+CNT_W-1:0] data;
  } wr_t;

  logic                   clk;
  logic                   rstn;
  logic                   start_i;
  logic                   stop_i;
  logic                   cont_mode_i;
  logic [NUM_OSC-1:0]     osc_mask_i;
  logic [TIMER_W-1:0]     settle_cycles_i;
  logic [TIMER_W-1:0]     count_cycles_i;
  logic [CNT_W-1:0]       osc_count_i;
  logic [NUM_OSC-1:0]     osc_en_o;
  logic [SEL_W-1:0]       osc_sel_o;
  logic                   cnt_rstn_o;
  logic                   cnt_en_o;
  logic                   wr_req_o;
  logic                   wr_ack_i;
  logic [ADDR_W-1:0]      wr_addr_o;
  logic [SEL_W+CNT_W-1:0] wr_data_o;
  logic                   busy_o;
  logic                   done_o;
  logic [15:0]            round_cnt_o;

  osc_meas_sequencer #(
    .NUM_OSC(NUM_OSC), .SEL_W(SEL_W), .CNT_W(CNT_W), .TIMER_W(TIMER_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .stop_i(stop_i), .cont_mode_i(cont_mode_i),
    .osc_mask_i(osc_mask_i), .settle_cycles_i(settle_cycles_i), .count_cycles_i(count_cycles_i),
    .osc_count_i(osc_count_i), .osc_en_o(osc_en_o), .osc_sel_o(osc_sel_o), .cnt_rstn_o(cnt_rstn_o),
    .cnt_en_o(cnt_en_o), .wr_req_o(wr_req_o), .wr_ack_i(wr_ack_i), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o), .round_cnt_o(round_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared oscillator counter model: synchronous clear, counts enabled cycles.
  always @(posedge clk) begin
    if (!cnt_rstn_o) osc_count_i <= '0;
    else if (cnt_en_o) osc_count_i <= osc_count_i + 16'd1;
  end

  int  n_total = 0;
  int  n_pass  = 0;
  wr_t exp_q[$];

  bit  ack_tied  = 1'b1;
  int  ack_delay = 0;
  int  req_wait  = 0;

  int  done_cnt, busy_cycles, req_cycles, en0_pre, en0_cnt, en2_cycles, onehot_viol;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic wr_t mk(input int addr, input int sel, input int cnt);
    wr_t w;
    w.addr = ADDR_W'(addr);
    w.data = {SEL_W'(sel), CNT_W'(cnt)};
    return w;
  endfunction

  // Ack driver, activity statistics and scoreboard monitor.
  always @(negedge clk) begin
    if (ack_tied) begin
      wr_ack_i = 1'b1;
      req_wait = 0;
    end else if (wr_req_o) begin
      wr_ack_i = (req_wait >= ack_delay);
      req_wait++;
    end else begin
      wr_ack_i = 1'b0;
      req_wait = 0;
    end
    if (done_o) done_cnt++;
    if (busy_o) busy_cycles++;
    if (osc_en_o[0] && !cnt_en_o) en0_pre++;
    if (osc_en_o[0] && cnt_en_o) en0_cnt++;
    if (osc_en_o[2]) en2_cycles++;
    if ($countones(osc_en_o) > 1) onehot_viol++;
    if (wr_req_o) begin
      req_cycles++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h, no write expected", wr_addr_o, wr_data_o);
      end else begin
        check("wr_addr", 64'(wr_addr_o), 64'(exp_q[0].addr));
        check("wr_data", 64'(wr_data_o), 64'(exp_q[0].data));
        if (wr_ack_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    done_cnt = 0; busy_cycles = 0; req_cycles = 0;
    en0_pre = 0; en0_cnt = 0; en2_cycles = 0; onehot_viol = 0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, 64'(done_o), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_osc_en"},   64'(osc_en_o),    64'd0);
    check({tag, "_osc_sel"},  64'(osc_sel_o),   64'd0);
    check({tag, "_cnt_rstn"}, 64'(cnt_rstn_o),  64'd0);
    check({tag, "_cnt_en"},   64'(cnt_en_o),    64'd0);
    check({tag, "_wr_req"},   64'(wr_req_o),    64'd0);
    check({tag, "_wr_addr"},  64'(wr_addr_o),   64'd0);
    check({tag, "_wr_data"},  64'(wr_data_o),   64'd0);
    check({tag, "_busy"},     64'(busy_o),      64'd0);
    check({tag, "_done"},     64'(done_o),      64'd0);
    check({tag, "_round"},    64'(round_cnt_o), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn = 1'b0; start_i = 1'b0; stop_i = 1'b0; cont_mode_i = 1'b0;
    osc_mask_i = '0; settle_cycles_i = '0; count_cycles_i = '0;
    wr_ack_i = 1'b0;
    clear_stats();
    repeat (3) tick();
    check_all_zero("in_reset");
    rstn = 1'b1;
    repeat (2) tick();
    check_all_zero("after_reset");

    // Two oscillators, settle 4, count 8, single round, ack tied high.
    osc_mask_i = 10'b0000000101; settle_cycles_i = 24'd4; count_cycles_i = 24'd8;
    exp_q.push_back(mk(0, 0, 8));
    exp_q.push_back(mk(1, 2, 8));
    clear_stats();
    pulse_start();
    wait_done(100, "t1");
    repeat (3) tick();
    check("t1_done_once",   64'(done_cnt),    64'd1);
    check("t1_round",       64'(round_cnt_o), 64'd1);
    check("t1_busy_low",    64'(busy_o),      64'd0);
    check("t1_busy_cycles", 64'(busy_cycles), 64'd34);
    check("t1_en0_settle",  64'(en0_pre),     64'd4);
    check("t1_en0_count",   64'(en0_cnt),     64'd8);
    check("t1_en2_cycles",  64'(en2_cycles),  64'd12);
    check("t1_onehot",      64'(onehot_viol), 64'd0);
    check("t1_addr",        64'(wr_addr_o),   64'd2);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Ack delayed by 5 request cycles; the monitor checks addr/data on every request cycle.
    ack_tied = 1'b0; ack_delay = 5;
    osc_mask_i = 10'b0000000010; settle_cycles_i = 24'd2; count_cycles_i = 24'd3;
    exp_q.push_back(mk(0, 1, 3));
    clear_stats();
    pulse_start();
    wait_done(100, "t2");
    check("t2_req_cycles",  64'(req_cycles),   64'd6);
    check("t2_addr",        64'(wr_addr_o),    64'd1);
    check("t2_round",       64'(round_cnt_o),  64'd1);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Continuous rounds on oscillator 9 with zero-length windows, then stop in CLR.
    ack_tied = 1'b1; cont_mode_i = 1'b1;
    osc_mask_i = 10'b1000000000; settle_cycles_i = 24'd0; count_cycles_i = 24'd0;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(i, 9, 1));
    clear_stats();
    pulse_start();
    n = 0;
    while (round_cnt_o != 16'd3 && n < 100) begin tick(); n++; end
    check("t3_round3",   64'(round_cnt_o), 64'd3);
    check("t3_addr3",    64'(wr_addr_o),   64'd3);
    check("t3_sel9",     64'(osc_sel_o),   64'd9);
    cont_mode_i = 1'b0;
    pulse_stop();
    check("t3_idle",      64'(busy_o),       64'd0);
    check("t3_done",      64'(done_o),       64'd1);
    check("t3_round_kept", 64'(round_cnt_o), 64'd3);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Stop during COUNT: immediate return to IDLE, no write.
    osc_mask_i = 10'b0000000001; settle_cycles_i = 24'd3; count_cycles_i = 24'd20;
    clear_stats();
    pulse_start();
    n = 0;
    while (!cnt_en_o && n < 50) begin tick(); n++; end
    check("t4_counting", 64'(cnt_en_o), 64'd1);
    repeat (2) tick();
    pulse_stop();
    check("t4_idle",    64'(busy_o),      64'd0);
    check("t4_done",    64'(done_o),      64'd1);
    check("t4_osc_off", 64'(osc_en_o),    64'd0);
    check("t4_cnt_off", 64'(cnt_en_o),    64'd0);
    check("t4_round",   64'(round_cnt_o), 64'd0);
    tick();
    check("t4_done_pulse", 64'(done_o),   64'd0);
    check("t4_no_req",  64'(req_cycles),  64'd0);

    // Stop while WRITE waits for a delayed ack: write completes, then IDLE.
    ack_tied = 1'b0; ack_delay = 5;
    osc_mask_i = 10'b0000000011; settle_cycles_i = 24'd1; count_cycles_i = 24'd2;
    exp_q.push_back(mk(0, 0, 2));
    clear_stats();
    pulse_start();
    n = 0;
    while (!wr_req_o && n < 50) begin tick(); n++; end
    check("t5_req_seen", 64'(wr_req_o), 64'd1);
    pulse_stop();
    wait_done(50, "t5");
    check("t5_req_cycles",  64'(req_cycles),   64'd6);
    check("t5_addr",        64'(wr_addr_o),    64'd1);
    check("t5_round",       64'(round_cnt_o),  64'd0);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    tick();
    check("t5_done_once",   64'(done_cnt),     64'd1);

    // Start with an empty mask, and start together with stop: both ignored.
    ack_tied = 1'b1;
    osc_mask_i = '0;
    clear_stats();
    pulse_start();
    repeat (5) tick();
    check("t6_mask0_busy", 64'(busy_cycles), 64'd0);
    check("t6_mask0_done", 64'(done_cnt),    64'd0);
    osc_mask_i = 10'b0000000001;
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    repeat (5) tick();
    check("t6_startstop_busy", 64'(busy_cycles), 64'd0);
    check("t6_startstop_done", 64'(done_cnt),    64'd0);

    // Start while busy and a mask change mid-round have no effect on the current round.
    osc_mask_i = 10'b0000000001; settle_cycles_i = 24'd2; count_cycles_i = 24'd2;
    exp_q.push_back(mk(0, 0, 2));
    clear_stats();
    pulse_start();
    repeat (3) tick();
    osc_mask_i = 10'b0000000011;
    pulse_start();
    wait_done(50, "t7");
    repeat (2) tick();
    check("t7_busy_cycles", 64'(busy_cycles),  64'd9);
    check("t7_round",       64'(round_cnt_o),  64'd1);
    check("t7_done_once",   64'(done_cnt),     64'd1);
    check("t7_queue_empty", 64'(exp_q.size()), 64'd0);

    // Address wrap: 1025 continuous single-oscillator rounds, writes 1023 then 0.
    cont_mode_i = 1'b1;
    osc_mask_i = 10'b0000000001; settle_cycles_i = 24'd0; count_cycles_i = 24'd0;
    for (int i = 0; i < 1025; i++) exp_q.push_back(mk(i % 1024, 0, 1));
    clear_stats();
    pulse_start();
    n = 0;
    while (round_cnt_o != 16'd1025 && n < 8000) begin tick(); n++; end
    check("t8_round", 64'(round_cnt_o), 64'd1025);
    cont_mode_i = 1'b0;
    pulse_stop();
    check("t8_addr_wrapped", 64'(wr_addr_o),    64'd1);
    check("t8_queue_empty",  64'(exp_q.size()), 64'd0);
    check("t8_idle",         64'(busy_o),       64'd0);

    // Asynchronous reset while WRITE waits for an ack.
    ack_tied = 1'b0; ack_delay = 10;
    osc_mask_i = 10'b0000000001; settle_cycles_i = 24'd1; count_cycles_i = 24'd1;
    exp_q.push_back(mk(0, 0, 1));
    pulse_start();
    n = 0;
    while (!wr_req_o && n < 50) begin tick(); n++; end
    check("t9_req_seen", 64'(wr_req_o), 64'd1);
    repeat (2) tick();
    #2 rstn = 1'b0;
    #1;
    check_all_zero("t9_async_reset");
    exp_q.delete();
    tick();
    rstn = 1'b1;
    ack_tied = 1'b1;
    repeat (2) tick();
    check("t9_stays_idle", 64'(busy_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/osc_meas_sequencer.md
Name: osc_meas_sequencer

Overview:
- Programmable measurement sequencer for the aging-sensor ring-oscillator array.
- Steps through the oscillators enabled in a run-time mask. For each one it runs a fixed sequence: reset the shared oscillator counter, settle, count for a set window, then hold.
- It then writes {osc index, count} into the result SRAM over a req/ack handshake.
- Supports single-round and continuous operation with register-programmed window lengths; replaces fixed free-running timing.

Parameters:
NUM_OSC, 10, number of oscillators (max 32)
SEL_W, 5, oscillator select width
CNT_W, 16, oscillator counter result width
TIMER_W, 24, settle/count window timer width
ADDR_W, 10, result SRAM address width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start_i  in  1  single-cycle start pulse
stop_i  in  1  single-cycle stop pulse
cont_mode_i  in  1  1 = repeat rounds until stopped, 0 = one round
osc_mask_i  in  NUM_OSC  oscillators to measure
settle_cycles_i  in  TIMER_W  osc-enabled cycles before counting
count_cycles_i  in  TIMER_W  counting window length in clk cycles
osc_count_i  in  CNT_W  shared oscillator counter value
osc_en_o  out  NUM_OSC  one-hot oscillator enable
osc_sel_o  out  SEL_W  index of the current oscillator
cnt_rstn_o  out  1  active-low clear of the shared counter
cnt_en_o  out  1  shared counter count enable
wr_req_o  out  1  SRAM write request
wr_ack_i  in  1  SRAM write acknowledge
wr_addr_o  out  ADDR_W  SRAM write address
wr_data_o  out  SEL_W+CNT_W  {osc_sel, count}
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse on return to IDLE
round_cnt_o  out  16  completed rounds since last start, wraps

Behaviour:
- Reset and clocking: reset rstn, asynchronous, active-low; clock clk. All outputs are registered and all reset to 0.
- States: IDLE, CLR, SETTLE, COUNT, HOLD, WRITE, NEXT.
- IDLE:
  - cnt_rstn_o=0, all enables 0.
  - On start_i with osc_mask_i!=0: latch mask, settle and count values; clear wr_addr_o and round_cnt_o; set osc_sel_o to the lowest set mask bit; go to CLR.
  - start_i with mask=0 is ignored, with no done_o.
  - start_i and stop_i in the same cycle: stop wins, block stays IDLE.
- CLR: exactly 1 cycle with cnt_rstn_o=0 and osc_en_o=0, then SETTLE.
- SETTLE:
  - cnt_rstn_o=1 from here until the next CLR/IDLE; osc_en_o[osc_sel]=1, cnt_en_o=0.
  - Lasts max(settle,1) cycles, then COUNT.
- COUNT: osc_en_o[osc_sel]=1, cnt_en_o=1 for exactly max(count,1) cycles, then HOLD.
- HOLD:
  - 2 cycles with osc_en_o=0 and cnt_en_o=0 (margin for counter synchronisation).
  - osc_count_i is captured on the last HOLD cycle into wr_data_o={osc_sel_o, osc_count_i}; then WRITE.
- WRITE:
  - wr_req_o=1; wr_addr_o and wr_data_o are held stable until the first cycle wr_ack_i=1.
  - On the next edge: wr_req_o drops, wr_addr_o increments (wraps 2^ADDR_W-1 -> 0), state goes to NEXT.
  - wr_ack_i outside WRITE is ignored.
- NEXT (1 cycle):
  - If a higher set mask bit exists: osc_sel_o takes it, go to CLR.
  - Otherwise the round is complete and round_cnt_o increments:
    - If cont_mode_i=1 and no stop is pending: re-latch mask, settle and count values (if the new mask is 0, end as stopped), select the lowest set bit, go to CLR.
    - Otherwise go to IDLE with done_o=1 for 1 cycle.
- stop_i handling:
  - In CLR, SETTLE, COUNT or HOLD: abort the same edge to IDLE. No write is issued, done_o pulses, round_cnt_o is unchanged.
  - In WRITE: latch stop pending, finish the handshake (wr_req_o is never withdrawn before ack), then IDLE with done_o.
  - In NEXT: treated as pending and goes to IDLE.
- Mid-round changes: start_i while busy is ignored. Changes to mask or window inputs mid-round take effect only at the next round start.
- Per-oscillator latency with ack at the first request cycle: 1 + S + C + 2 + 1 + 1 cycles (CLR, SETTLE, COUNT, HOLD, WRITE, NEXT).
- Asynchronous reset mid-round forces IDLE immediately; any outstanding wr_req_o drops.

Test Plan:
- Mask=10'b0000000101, settle=4, count=8, cont=0, ack tied 1, counter model counts cnt_en_o cycles:
  - osc_en_o[0] high for 12 cycles with cnt_en_o for the last 8; writes {0,8}@0 then {2,8}@1.
  - done_o pulses once, round_cnt_o=1, busy_o low afterwards.
- Ack delayed 5 cycles: wr_req_o, wr_addr_o and wr_data_o stay stable for all 5 cycles; the address increments only after ack.
- cont=1, mask=10'b1000000000, settle=0, count=0:
  - Windows are treated as 1 cycle each.
  - After 3 rounds round_cnt_o=3; wr_addr_o reaches 3.
- stop_i during COUNT -> IDLE next cycle, no wr_req_o, done_o pulse. stop_i during a WRITE waiting for ack -> write completes, then IDLE, done_o pulse.
- start_i with mask=0 -> stays IDLE, no done_o. start_i together with stop_i -> stays IDLE. start_i while busy -> no effect.
- wr_addr_o preset by 1023 writes with ADDR_W=10: the next write lands at 1023, the following one at 0. rstn asserted during WRITE -> all outputs 0 immediately.
